// File: rtl/i2c_arbiter_if.sv
// Arbiter-to-I2C-engine transaction bus.
// master: arbiter side; slave: engine side.
interface i2c_arbiter_if;
    logic       i2c_start;
    logic       i2c_done;
    logic [6:0] addr;
    logic [1:0] num_wr_bytes;
    logic [1:0] num_rd_bytes;
    logic [7:0] wr_data0;
    logic [7:0] wr_data1;
    logic [7:0] wr_data2;
    logic [7:0] i2c_rd_data0;
    logic [7:0] i2c_rd_data1;

    modport master (
        output i2c_start, addr, num_wr_bytes, num_rd_bytes,
        output wr_data0, wr_data1, wr_data2,
        input  i2c_done, i2c_rd_data0, i2c_rd_data1
    );

    modport slave (
        input  i2c_start, addr, num_wr_bytes, num_rd_bytes,
        input  wr_data0, wr_data1, wr_data2,
        output i2c_done, i2c_rd_data0, i2c_rd_data1
    );
endinterface

// File: rtl/i2c_arbiter.sv
// Round-robin arbiter sharing one I2C engine among NUM_REQ requesters.
// Optional watchdog in WAIT enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_start,
    input  logic [7*NUM_REQ-1:0] req_addr,
    input  logic [2*NUM_REQ-1:0] req_num_wr_bytes,
    input  logic [2*NUM_REQ-1:0] req_num_rd_bytes,
    input  logic [8*NUM_REQ-1:0] req_wr_data0,
    input  logic [8*NUM_REQ-1:0] req_wr_data1,
    input  logic [8*NUM_REQ-1:0] req_wr_data2,
    output logic [NUM_REQ-1:0]   req_done,
    output logic [7:0]           rd_data0,
    output logic [7:0]           rd_data1,
    output logic [NUM_REQ-1:0]   req_err,
    output logic                 busy,
    i2c_arbiter_if.master        eng
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t             state, state_n;
    logic [NUM_REQ-1:0] pending, clr_mask;
    logic [GW-1:0]      grant, last_grant, next_grant, idx;
    logic               found, take, tmo;

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 2) begin : g_cfg_err
        $error("i2c_arbiter: unsupported parameter values");
    end

    assign take     = (state == IDLE) && found;
    assign clr_mask = take ? (NUM_REQ'(1) << next_grant) : '0;
    assign busy     = (state != IDLE);
    assign req_done = (state == DONE) ? (NUM_REQ'(1) << grant) : '0;

    assign eng.i2c_start = (state == ISSUE);

    // Round-robin search starting just above the last served requester.
    always_comb begin
        found      = 1'b0;
        next_grant = last_grant;
        idx        = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = GW'((int'(last_grant) + k) % NUM_REQ);
            if (!found && pending[idx]) begin
                found      = 1'b1;
                next_grant = idx;
            end
        end
    end

    // Next-state logic: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (found) state_n = ISSUE;
            ISSUE:   state_n = WAIT;
            WAIT:    if (eng.i2c_done || tmo) state_n = DONE;
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State, pending set/clear, grant and engine field capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= IDLE;
            pending          <= '0;
            grant            <= '0;
            last_grant       <= GW'(NUM_REQ - 1);
            eng.addr         <= '0;
            eng.num_wr_bytes <= '0;
            eng.num_rd_bytes <= '0;
            eng.wr_data0     <= '0;
            eng.wr_data1     <= '0;
            eng.wr_data2     <= '0;
        end else begin
            state   <= state_n;
            // A start pulse in the grant cycle wins so it is never lost.
            pending <= (pending & ~clr_mask) | req_start;
            if (take) begin
                grant            <= next_grant;
                eng.addr         <= req_addr[int'(next_grant)*7 +: 7];
                eng.num_wr_bytes <= req_num_wr_bytes[int'(next_grant)*2 +: 2];
                eng.num_rd_bytes <= req_num_rd_bytes[int'(next_grant)*2 +: 2];
                eng.wr_data0     <= req_wr_data0[int'(next_grant)*8 +: 8];
                eng.wr_data1     <= req_wr_data1[int'(next_grant)*8 +: 8];
                eng.wr_data2     <= req_wr_data2[int'(next_grant)*8 +: 8];
            end
            if (state == DONE) last_grant <= grant;
        end
    end

`ifdef I2C_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] tcnt;

    assign tmo = (state == WAIT) && !eng.i2c_done &&
                 (tcnt == TW'(TIMEOUT_CYCLES - 1));

    // Read capture, watchdog counter and sticky timeout flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
            req_err  <= '0;
            tcnt     <= '0;
        end else begin
            if (take) tcnt <= '0;
            else if (state == WAIT) tcnt <= tcnt + 1'b1;
            if (state == WAIT && eng.i2c_done) begin
                rd_data0 <= eng.i2c_rd_data0;
                rd_data1 <= eng.i2c_rd_data1;
            end else if (tmo) begin
                rd_data0       <= 8'h00;
                rd_data1       <= 8'h00;
                req_err[grant] <= 1'b1;
            end
        end
    end
`else
    assign tmo     = 1'b0;
    assign req_err = '0;

    // Read capture on engine completion.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_data0 <= '0;
            rd_data1 <= '0;
        end else if (state == WAIT && eng.i2c_done) begin
            rd_data0 <= eng.i2c_rd_data0;
            rd_data1 <= eng.i2c_rd_data1;
        end
    end
`endif

endmodule

// File: tb/tb_i2c_arbiter.sv
// Bench for i2c_arbiter: directed vectors, corner sequences and
// random traffic against a transaction-level round-robin model.
module tb_i2c_arbiter;
    localparam int N = 4;

    logic clk = 1'b0;
    logic reset;
    logic [N-1:0]   req_start, req_done, req_err;
    logic [7*N-1:0] req_addr;
    logic [2*N-1:0] req_num_wr_bytes, req_num_rd_bytes;
    logic [8*N-1:0] req_wr_data0, req_wr_data1, req_wr_data2;
    logic [7:0]     rd_data0, rd_data1;
    logic           busy;

    i2c_arbiter_if eng();

    i2c_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(50)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_start        (req_start),
        .req_addr         (req_addr),
        .req_num_wr_bytes (req_num_wr_bytes),
        .req_num_rd_bytes (req_num_rd_bytes),
        .req_wr_data0     (req_wr_data0),
        .req_wr_data1     (req_wr_data1),
        .req_wr_data2     (req_wr_data2),
        .req_done         (req_done),
        .rd_data0         (rd_data0),
        .rd_data1         (rd_data1),
        .req_err          (req_err),
        .busy             (busy),
        .eng              (eng)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int ncyc = 0;

    int eng_lat = 2;
    bit eng_hang = 1'b0;
    bit eng_rand = 1'b0;
    int man_req = 0;
    int man_ack = 0;

    // Engine returns data derived from the device address.
    function automatic logic [7:0] f0(logic [6:0] a);
        return {1'b0, a} ^ 8'h5A;
    endfunction

    function automatic logic [7:0] f1(logic [6:0] a);
        return {1'b0, a} ^ 8'hC3;
    endfunction

    // I2C engine model.
    initial begin
        int lat;
        eng.i2c_done = 1'b0;
        eng.i2c_rd_data0 = '0;
        eng.i2c_rd_data1 = '0;
        forever begin
            @(negedge clk);
            if (man_req != man_ack) begin
                man_ack++;
                eng.i2c_rd_data0 = f0(eng.addr);
                eng.i2c_rd_data1 = f1(eng.addr);
                eng.i2c_done = 1'b1;
                @(negedge clk);
                eng.i2c_done = 1'b0;
            end else if (eng.i2c_start) begin
                lat = eng_rand ? int'($urandom_range(6, 1)) : eng_lat;
                repeat (lat) @(negedge clk);
                if (!eng_hang) begin
                    eng.i2c_rd_data0 = f0(eng.addr);
                    eng.i2c_rd_data1 = f1(eng.addr);
                    eng.i2c_done = 1'b1;
                    @(negedge clk);
                    eng.i2c_done = 1'b0;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        ncyc++;
    endtask

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic set_req(int i, logic [6:0] a, logic [1:0] nw,
                           logic [1:0] nr, logic [7:0] w0,
                           logic [7:0] w1, logic [7:0] w2);
        req_addr[i*7 +: 7]         = a;
        req_num_wr_bytes[i*2 +: 2] = nw;
        req_num_rd_bytes[i*2 +: 2] = nr;
        req_wr_data0[i*8 +: 8]     = w0;
        req_wr_data1[i*8 +: 8]     = w1;
        req_wr_data2[i*8 +: 8]     = w2;
    endtask

    task automatic pulse(logic [N-1:0] m);
        req_start = m;
        tick();
        req_start = '0;
    endtask

    task automatic wait_done(output int who, output int at, input int budget);
        who = -1;
        at = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (req_done != '0) begin
                at = ncyc;
                for (int i = 0; i < N; i++) if (req_done[i]) who = i;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_done: no req_done within %0d cycles", budget);
    endtask

    task automatic wait_start(output int s, input int budget);
        s = 0;
        for (int c = 0; c < budget; c++) begin
            tick();
            if (eng.i2c_start) begin
                s = ncyc;
                return;
            end
        end
        n_chk++;
        n_fail++;
        $display("FAIL wait_start: no i2c_start within %0d cycles", budget);
    endtask

    // Transaction-level reference model for random traffic.
    bit         outst[N];
    bit         issued[N];
    int         pcyc[N];
    logic [6:0] ma[N];
    logic [1:0] mnw[N], mnr[N];
    logic [7:0] mw0[N], mw1[N], mw2[N];
    int         lg;
    int         cur;

    task automatic obs();
        int e;
        int j;
        e = -1;
        if (eng.i2c_start) begin
            for (int k = 1; k <= N; k++) begin
                j = (lg + k) % N;
                if (e < 0 && outst[j] && !issued[j] && pcyc[j] <= ncyc - 2)
                    e = j;
            end
            if (e < 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rnd_start: unexpected i2c_start at %0d", ncyc);
            end else begin
                chk("rnd_fields",
                    {eng.addr, eng.num_wr_bytes, eng.num_rd_bytes,
                     eng.wr_data0, eng.wr_data1, eng.wr_data2},
                    {ma[e], mnw[e], mnr[e], mw0[e], mw1[e], mw2[e]});
                issued[e] = 1'b1;
                cur = e;
            end
        end
        if (req_done != '0) begin
            if (cur < 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL rnd_done: req_done %0h with nothing issued",
                         req_done);
            end else begin
                chk("rnd_done_sel", req_done, N'(1) << cur);
                chk("rnd_rd", {rd_data0, rd_data1}, {f0(ma[cur]), f1(ma[cur])});
                outst[cur] = 1'b0;
                issued[cur] = 1'b0;
                lg = cur;
                cur = -1;
            end
        end
    endtask

    typedef struct {
        int         r;
        logic [6:0] a;
        logic [1:0] nw;
        logic [1:0] nr;
        logic [7:0] w0, w1, w2;
        int         lat;
        logic [7:0] e0, e1;
    } vec_t;

    vec_t tbl[4];

    initial begin
        int who, at, p, s;
        bit saw_done, saw_start, saw_err, any_out;
        logic [N-1:0] m;

        tbl[0] = '{1, 7'h20, 2'd3, 2'd0, 8'h06, 8'hFF, 8'h00, 20, 8'h7A, 8'hE3};
        tbl[1] = '{2, 7'h00, 2'd0, 2'd2, 8'h00, 8'h00, 8'h00, 5,  8'h5A, 8'hC3};
        tbl[2] = '{0, 7'h7F, 2'd1, 2'd1, 8'hA5, 8'h00, 8'h00, 1,  8'h25, 8'hBC};
        tbl[3] = '{3, 7'h55, 2'd2, 2'd1, 8'h12, 8'h34, 8'h00, 3,  8'h0F, 8'h96};

        reset = 1'b1;
        req_start = '0;
        req_addr = '0;
        req_num_wr_bytes = '0;
        req_num_rd_bytes = '0;
        req_wr_data0 = '0;
        req_wr_data1 = '0;
        req_wr_data2 = '0;
        repeat (3) tick();
        chk("reset_ctrl", {busy, eng.i2c_start, req_done, req_err}, '0);
        chk("reset_data", {rd_data0, rd_data1, eng.addr, eng.num_wr_bytes,
            eng.num_rd_bytes, eng.wr_data0, eng.wr_data1, eng.wr_data2}, '0);
        reset = 1'b0;
        tick();

        // Single requests from the vector table.
        for (int t = 0; t < 4; t++) begin
            set_req(tbl[t].r, tbl[t].a, tbl[t].nw, tbl[t].nr,
                    tbl[t].w0, tbl[t].w1, tbl[t].w2);
            eng_lat = tbl[t].lat;
            p = ncyc;
            req_start = N'(1) << tbl[t].r;
            tick();
            req_start = '0;
            chk("t_start_early", eng.i2c_start, 0);
            tick();
            chk("t_start_lat2", eng.i2c_start, 1);
            chk("t_fields", {eng.addr, eng.num_wr_bytes, eng.num_rd_bytes,
                eng.wr_data0, eng.wr_data1, eng.wr_data2},
                {tbl[t].a, tbl[t].nw, tbl[t].nr, tbl[t].w0, tbl[t].w1, tbl[t].w2});
            wait_done(who, at, 100);
            chk("t_who", 64'(who), 64'(tbl[t].r));
            chk("t_done_cyc", 64'(at - p), 64'(tbl[t].lat + 3));
            chk("t_rd", {rd_data0, rd_data1}, {tbl[t].e0, tbl[t].e1});
            chk("t_fields_hold", eng.addr, tbl[t].a);
            tick();
            chk("t_done_1cyc", {req_done, busy}, '0);
        end

        // Engine done while idle must be ignored.
        man_req++;
        saw_done = 1'b0;
        repeat (5) begin
            tick();
            saw_done |= (req_done != '0) | busy;
        end
        chk("idle_done_ignored", saw_done, 0);

        // Contention: all four at once, twice.
        for (int r = 0; r < N; r++)
            set_req(r, 7'(7'h10 + r), 2'd1, 2'd0, 8'(8'hA0 + r), 8'h00, 8'h00);
        eng_lat = 3;
        for (int rep = 0; rep < 2; rep++) begin
            pulse('1);
            for (int k = 0; k < N; k++) begin
                wait_done(who, at, 100);
                chk("cont_order", 64'(who), 64'(k));
            end
        end

        // Requester 0 re-requests during its own WAIT with 1 pending.
        eng_lat = 8;
        pulse(4'b0001);
        tick();
        tick();
        chk("rereq_busy", busy, 1);
        pulse(4'b0010);
        pulse(4'b0001);
        wait_done(who, at, 100);
        chk("rereq_first", 64'(who), 64'd0);
        wait_done(who, at, 100);
        chk("rereq_second", 64'(who), 64'd1);
        wait_done(who, at, 100);
        chk("rereq_third", 64'(who), 64'd0);

        // Engine never completes.
        set_req(3, 7'h33, 2'd1, 2'd1, 8'h77, 8'h00, 8'h00);
        set_req(0, 7'h0A, 2'd1, 2'd0, 8'h01, 8'h00, 8'h00);
        eng_hang = 1'b1;
        eng_lat = 2;
        pulse(4'b1000);
        wait_start(s, 10);
        pulse(4'b0001);
`ifdef I2C_ARB_TIMEOUT_EN
        wait_done(who, at, 200);
        chk("tmo_who", 64'(who), 64'd3);
        chk("tmo_cycles", 64'(at - s), 64'd51);
        chk("tmo_rd_zero", {rd_data0, rd_data1}, '0);
        chk("tmo_err", req_err, 4'b1000);
        eng_hang = 1'b0;
        wait_done(who, at, 100);
        chk("tmo_next_who", 64'(who), 64'd0);
        chk("tmo_next_rd", {rd_data0, rd_data1}, {f0(7'h0A), f1(7'h0A)});
        chk("tmo_err_sticky", req_err, 4'b1000);
`else
        saw_done = 1'b0;
        saw_err = 1'b0;
        repeat (70) begin
            tick();
            saw_done |= (req_done != '0);
            saw_err |= (req_err != '0);
        end
        chk("hang_no_done", saw_done, 0);
        chk("hang_busy", busy, 1);
        chk("hang_no_err", saw_err, 0);
        man_req++;
        eng_hang = 1'b0;
        wait_done(who, at, 20);
        chk("hang_who", 64'(who), 64'd3);
        chk("hang_rd", {rd_data0, rd_data1}, {f0(7'h33), f1(7'h33)});
        wait_done(who, at, 100);
        chk("hang_next_who", 64'(who), 64'd0);
`endif

        // Reset during WAIT, then a late engine done.
        eng_hang = 1'b1;
        eng_lat = 1;
        pulse(4'b0001);
        tick();
        tick();
        chk("rst_mid_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        tick();
        man_req++;
        saw_done = 1'b0;
        saw_start = 1'b0;
        repeat (10) begin
            tick();
            saw_done |= (req_done != '0);
            saw_start |= eng.i2c_start;
        end
        chk("rst_mid_no_done", saw_done, 0);
        chk("rst_mid_no_start", saw_start, 0);
        chk("rst_mid_idle", {busy, dut.pending}, '0);
        eng_hang = 1'b0;

        // Random traffic against the model.
        eng_rand = 1'b1;
        lg = N - 1;
        cur = -1;
        for (int i = 0; i < N; i++) begin
            outst[i] = 1'b0;
            issued[i] = 1'b0;
            pcyc[i] = 0;
        end
        for (int c = 0; c < 3000; c++) begin
            tick();
            obs();
            m = '0;
            for (int i = 0; i < N; i++) begin
                if (!outst[i] && $urandom_range(7, 0) == 0) begin
                    ma[i] = 7'($urandom);
                    mnw[i] = 2'($urandom);
                    mnr[i] = 2'($urandom);
                    mw0[i] = 8'($urandom);
                    mw1[i] = 8'($urandom);
                    mw2[i] = 8'($urandom);
                    set_req(i, ma[i], mnw[i], mnr[i], mw0[i], mw1[i], mw2[i]);
                    outst[i] = 1'b1;
                    pcyc[i] = ncyc;
                    m[i] = 1'b1;
                end
            end
            req_start = m;
        end
        tick();
        req_start = '0;
        obs();
        any_out = 1'b1;
        for (int c = 0; c < 1000 && any_out; c++) begin
            tick();
            obs();
            any_out = 1'b0;
            for (int i = 0; i < N; i++) any_out |= outst[i];
        end
        chk("rnd_drain", any_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/i2c_arbiter.md
I2C_ARBITER -- requirements
Module: i2c_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of requester ports (2..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: watchdog limit in clk cycles, used only when I2C_ARB_TIMEOUT_EN is defined.
REQ-003 clk  in  1  Single clock; all logic is on its rising edge.
REQ-004 reset  in  1  Synchronous, active-high reset.
REQ-005 req_start  in  NUM_REQ  Per-requester one-cycle start pulse.
REQ-006 req_addr  in  7*NUM_REQ  Per-requester 7-bit device address.
REQ-007 req_num_wr_bytes / req_num_rd_bytes  in  2*NUM_REQ each  Per-requester write and read byte counts.
REQ-008 req_wr_data0/1/2  in  8*NUM_REQ each  Per-requester write bytes.
REQ-009 req_done  out  NUM_REQ  Per-requester one-cycle completion pulse.
REQ-010 rd_data0, rd_data1  out  8 each  Read bytes, shared by all requesters and valid in the req_done cycle.
REQ-011 req_err  out  NUM_REQ  Sticky per-requester timeout flag.
REQ-012 i2c_start  out  1  One-cycle start pulse to the I2C engine.
REQ-013 i2c_done  in  1  Completion pulse from the I2C engine.
REQ-014 addr, num_wr_bytes, wr_data0/1/2, num_rd_bytes  out  Muxed transaction fields to the engine.
REQ-015 i2c_rd_data0, i2c_rd_data1  in  8 each  Read bytes from the engine.
REQ-016 busy  out  1  High whenever state is not IDLE.

Function
REQ-017 A req_start pulse SHALL set pending[i]; pending[i] SHALL clear only in the cycle requester i is granted.
REQ-018 A req_start pulse while pending[i] is already set SHALL be absorbed; there is no second queue entry.
REQ-019 A req_start pulse from the currently granted requester SHALL set pending[i] and SHALL queue one further transaction.
REQ-020 Each requester SHALL hold its fields stable from the cycle after its start pulse until its req_done pulse.
REQ-021 State machine: IDLE -> ISSUE -> WAIT -> DONE -> IDLE.
REQ-022 In IDLE with any pending bit set, the arbiter SHALL select grant by round-robin, searching upward from last_grant+1 modulo NUM_REQ, and move to ISSUE.
REQ-023 After reset, last_grant SHALL equal NUM_REQ-1, so requester 0 has first priority.
REQ-024 On entry to ISSUE, the arbiter SHALL register the granted requester's fields into addr, num_wr_bytes, num_rd_bytes and wr_data0/1/2.
REQ-025 i2c_start SHALL be high for exactly the one ISSUE cycle; the registered fields SHALL be valid in that cycle and SHALL hold until the return to IDLE.
REQ-026 In WAIT, an i2c_done pulse SHALL capture i2c_rd_data0/1 into rd_data0/1 and move to DONE.
REQ-027 In DONE, the arbiter SHALL pulse req_done[grant] for one cycle, set last_grant to grant, and return to IDLE.
REQ-028 i2c_done outside WAIT SHALL be ignored.
REQ-029 Latency from a start pulse to i2c_start SHALL be 2 cycles when the arbiter is IDLE with nothing else pending.
REQ-030 Minimum gap between back-to-back i2c_start pulses SHALL be engine latency + 3 cycles.
REQ-031 With all requesters pending, grants SHALL rotate strictly; no requester waits more than NUM_REQ-1 transactions.
REQ-032 At most one req_done bit SHALL be high in any cycle.

Reset
REQ-033 Reset SHALL clear pending, req_done, req_err, i2c_start, busy, rd_data0/1 and all muxed field outputs to 0, set state to IDLE, and set last_grant to NUM_REQ-1.
REQ-034 Reset asserted mid-transaction SHALL abandon that transaction with no req_done pulse; a late i2c_done after reset SHALL be ignored.

Configuration
REQ-035 Macro I2C_ARB_TIMEOUT_EN defined: in WAIT, a counter SHALL increment each cycle.
REQ-036 On reaching TIMEOUT_CYCLES-1 with no i2c_done, the arbiter SHALL load rd_data0/1 with 8'h00, set req_err[grant], go to DONE, and pulse req_done as normal.
REQ-037 The timeout counter SHALL clear on entry to ISSUE.
REQ-038 Macro not defined: WAIT SHALL persist until i2c_done, req_err SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-039 Single request: req_start[1] pulse at cycle 10 with addr 0x20, wr 3 bytes {06,FF,00}, engine done 20 cycles later -> i2c_start at cycle 12 with those fields; req_done[1] one cycle after i2c_done.
REQ-040 Contention: req_start[0..3] pulsed in the same cycle -> grant order 0,1,2,3; then all four re-pulsed -> order 0,1,2,3 again.
REQ-041 Read return: requester 2 issues 0 wr / 2 rd, engine returns 0x5A,0xC3 -> rd_data0=0x5A and rd_data1=0xC3 in the req_done[2] cycle.
REQ-042 Re-request during own transaction: req_start[0] pulsed while requester 0 is in WAIT, requester 1 pending -> next grant 1, then 0.
REQ-043 Reset in WAIT, then i2c_done 3 cycles later -> no req_done, busy=0, pending=0.
REQ-044 I2C_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=50 and the engine never done -> req_done[3] at i2c_start+51 cycles, rd_data=0, req_err[3]=1 (sticky); next pending request served normally.
